// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM state encoding and FIFO entry layout.
package fetch_pkg;

    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs toward decode; flush empties it on the next edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_en;

    // Popping an empty FIFO is silently ignored
    assign pop_en = pop && !empty;
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop_en);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding req/gnt/rvalid request, credit-gated issue,
// redirect flush with stale-response discard, and a FIFO of fetched instructions toward decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [ILEN-1:0] fetch_pc_q;
    logic [ILEN-1:0] redirect_target;

    fetch_entry_t     push_data;
    fetch_entry_t     head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             do_push;
    logic             do_pop;
    logic             outstanding;
    logic [OCC_W-1:0] occupancy;
    logic             credit;
    logic             granted;

    assign redirect_target = redirect_pc_i & ~32'h3;

    // A response that coincides with a redirect is stale and never reaches the FIFO
    assign do_push     = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
    assign do_pop      = instr_ready_i && !fifo_empty;
    assign outstanding = (state_q == WAIT) || (state_q == DISCARD);
    assign occupancy   = OCC_W'(fifo_count) + OCC_W'(do_push) - OCC_W'(do_pop) + OCC_W'(outstanding);
    assign credit      = occupancy < OCC_W'(DEPTH);
    assign granted     = imem_req_o && imem_gnt_i;

    assign push_data.pc    = fetch_pc_q - 32'd4;
    assign push_data.instr = imem_rdata_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (granted) state_d = redirect_i ? DISCARD : WAIT;
            WAIT: begin
                if (imem_rvalid_i)   state_d = REQ;
                else if (redirect_i) state_d = DISCARD;
            end
            DISCARD: if (imem_rvalid_i) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = fetch_pc_q;
        if (state_q == REQ) begin
            imem_req_o = credit;
        end
    end

    // Redirect target wins over the post-grant increment
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fetch_pc_q <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc_q <= redirect_target;
        end else if (granted) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push      (do_push),
        .push_data (push_data),
        .pop       (do_pop),
        .flush     (redirect_i),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;

    push_when_full_a: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(do_push && fifo_full));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: per-cycle stimulus/expectation table plus a reset-in-flight sequence.
module tb_fetch_ctrl;

    logic        clk_i;
    logic        reset_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    // Memory contents the bench pretends live at each word address
    function automatic logic [31:0] rd(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(input logic r, input logic [31:0] rpc, input logic g,
                                input logic rv, input logic [31:0] rdat, input logic rdy,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic ev, input logic [31:0] epc);
        vec_t v;
        v.redirect = r;  v.rpc = rpc;  v.gnt = g;  v.rvalid = rv;  v.rdata = rdat;
        v.ready = rdy;   v.exp_req = ereq;  v.exp_addr = eaddr;  v.exp_valid = ev;
        v.exp_pc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] rpc, input logic g,
                         input logic rv, input logic [31:0] rdat, input logic rdy);
        redirect_i = r;  redirect_pc_i = rpc;  imem_gnt_i = g;
        imem_rvalid_i = rv;  imem_rdata_i = rdat;  instr_ready_i = rdy;
    endtask

    task automatic check_outputs(input string tag, input logic ereq, input logic [31:0] eaddr,
                                 input logic ev, input logic [31:0] epc);
        chk({tag, " req"},   32'(imem_req_o), 32'(ereq));
        chk({tag, " addr"},  imem_addr_o, eaddr);
        chk({tag, " valid"}, 32'(instr_valid_o), 32'(ev));
        if (ev) begin
            chk({tag, " pc"},    instr_pc_o, epc);
            chk({tag, " instr"}, instr_o, rd(epc));
        end
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        reset_i = 1'b0;

        // Basic streaming: gnt always high, rvalid one cycle after gnt
        vecs.push_back(mk(0, 0, 1, 0, 0,                1, 0, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,                1, 1, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, rd(32'h0),        1, 0, 32'h0000_0004, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,                1, 1, 32'h0000_0004, 1, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, rd(32'h4),        1, 0, 32'h0000_0008, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,                1, 1, 32'h0000_0008, 1, 32'h4));
        vecs.push_back(mk(0, 0, 1, 1, rd(32'h8),        1, 0, 32'h0000_000C, 0, 0));
        // Decode stalls for 10 cycles: FIFO fills to two entries, then req is withheld
        vecs.push_back(mk(0, 0, 1, 0, 0,                0, 1, 32'h0000_000C, 1, 32'h8));
        vecs.push_back(mk(0, 0, 1, 1, rd(32'hC),        0, 0, 32'h0000_0010, 1, 32'h8));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0, 32'h0000_0010, 1, 32'h8));
        vecs.push_back(mk(0, 0, 1, 0, 0,                1, 1, 32'h0000_0010, 1, 32'h8));
        vecs.push_back(mk(0, 0, 1, 1, rd(32'h10),       1, 0, 32'h0000_0014, 1, 32'hC));
        vecs.push_back(mk(0, 0, 1, 0, 0,                0, 1, 32'h0000_0014, 1, 32'h10));
        // Redirect to 0x100 while waiting: flush, stale response dropped
        vecs.push_back(mk(1, 32'h100, 1, 0, 0,          0, 0, 32'h0000_0018, 1, 32'h10));
        vecs.push_back(mk(0, 0, 1, 1, rd(32'h14),       1, 0, 32'h0000_0100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,                1, 1, 32'h0000_0100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, rd(32'h100),      1, 0, 32'h0000_0104, 0, 0));
        // Redirect to 0x203 in the grant cycle: discard, next address 0x200
        vecs.push_back(mk(1, 32'h203, 1, 0, 0,          1, 1, 32'h0000_0104, 1, 32'h100));
        vecs.push_back(mk(0, 0, 1, 0, 0,                1, 0, 32'h0000_0200, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, rd(32'h104),      1, 0, 32'h0000_0200, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,                1, 1, 32'h0000_0200, 0, 0));
        // Redirect together with rvalid, target near the top of the address space
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 1, 1, rd(32'h200), 1, 0, 32'h0000_0204, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,                1, 1, 32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, rd(32'hFFFF_FFFC), 1, 0, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,                1, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC));
        // Park one entry in the FIFO and leave a request outstanding before reset
        vecs.push_back(mk(0, 0, 1, 1, rd(32'h0),        0, 0, 32'h0000_0004, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,                0, 1, 32'h0000_0004, 1, 32'h0));

        repeat (2) @(negedge clk_i);
        #1;
        chk("reset req",   32'(imem_req_o), 32'h0);
        chk("reset valid", 32'(instr_valid_o), 32'h0);
        chk("reset instr", instr_o, 32'h0);
        chk("reset pc",    instr_pc_o, 32'h0);
        chk("reset addr",  imem_addr_o, 32'h0);
        reset_i = 1'b1;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk_i);
            drive(vecs[i].redirect, vecs[i].rpc, vecs[i].gnt, vecs[i].rvalid,
                  vecs[i].rdata, vecs[i].ready);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                          vecs[i].exp_valid, vecs[i].exp_pc);
        end

        // Reset pulse while waiting for a response, with a valid FIFO head
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check_outputs("pre_reset", 1'b0, 32'h0000_0008, 1'b1, 32'h0);
        reset_i = 1'b0;
        #1;
        chk("async reset req",   32'(imem_req_o), 32'h0);
        chk("async reset addr",  imem_addr_o, 32'h0);
        chk("async reset valid", 32'(instr_valid_o), 32'h0);
        chk("async reset instr", instr_o, 32'h0);
        chk("async reset pc",    instr_pc_o, 32'h0);
        @(negedge clk_i);
        reset_i = 1'b1;
        // Late response for the pre-reset request must be ignored
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        #1;
        check_outputs("post_reset idle", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        check_outputs("post_reset req", 1'b1, 32'h0, 1'b0, 32'h0);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 1'b1, rd(32'h0), 1'b1);
        #1;
        check_outputs("post_reset wait", 1'b0, 32'h4, 1'b0, 32'h0);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        check_outputs("post_reset first", 1'b1, 32'h4, 1'b1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
